lpc_capture_ctrl: RTL and testbench
===================================

LPC_CAPTURE_CTRL -- requirements
Module: lpc_capture_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; SHALL be a power of two, 2..16.
REQ-002 Parameter FILT_LO, default 16'h0080, lower inclusive I/O address bound for the filter.
REQ-003 Parameter FILT_HI, default 16'h0087, upper inclusive I/O address bound for the filter.
REQ-004 lpc_clock  in  1  clock; all state updates on its rising edge.
REQ-005 lpc_reset  in  1  reset; asynchronous, active-low.
REQ-006 enable  in  1  capture run request from host logic.
REQ-007 dec_cyctype_dir  in  4  cycle type/direction from the LPC decoder.
REQ-008 dec_addr  in  32  decoder address; only [15:0] is used.
REQ-009 dec_data  in  8  decoder data byte.
REQ-010 dec_latch  in  1  decoder done strobe; a rising edge marks one completed transaction.
REQ-011 out_ready  in  1  downstream (serializer) accepts the current record.
REQ-012 out_valid  out  1  record available at the FIFO head.
REQ-013 out_cyctype_dir  out  4 / out_addr  out  16 / out_data  out  8  head record fields.
REQ-014 fifo_level  out  5  current entry count.
REQ-015 overflow_cnt  out  8  count of transactions dropped because the FIFO was full; saturates at 255.
REQ-016 busy  out  1  high in states RUN and DRAIN.

Function
REQ-017 The block SHALL register dec_latch into latch_q every cycle; event = dec_latch & ~latch_q.
REQ-018 States SHALL be OFF, RUN and DRAIN; OFF->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->OFF when fifo_level=0 and no pop occurs that cycle; DRAIN->RUN when enable=1.
REQ-019 An event SHALL be capturable only in RUN; events in OFF or DRAIN SHALL be ignored and SHALL NOT count as overflow.
REQ-020 A capturable event SHALL write {dec_cyctype_dir, dec_addr[15:0], dec_data} at the end of the event cycle; out_valid SHALL rise the following cycle when the FIFO was empty (latency 1).
REQ-021 A pop SHALL occur when out_valid=1 and out_ready=1; head fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 FIFO full with a capturable event and no pop: the record SHALL be dropped and overflow_cnt incremented unless it is 255.
REQ-023 FIFO full with a capturable event and a pop in the same cycle: the record SHALL be accepted and fifo_level SHALL stay at DEPTH.
REQ-024 FIFO empty: out_valid=0, so no pop is possible; a push SHALL still be accepted.
REQ-025 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; fifo_level SHALL be in 0..DEPTH.
REQ-026 out_valid SHALL equal (fifo_level != 0) in every state, including DRAIN and OFF.

Reset
REQ-027 Asserting lpc_reset low SHALL immediately force: state OFF, pointers 0, fifo_level 0, out_valid 0, overflow_cnt 0, latch_q 1, busy 0.
REQ-028 latch_q=1 at reset SHALL ensure a dec_latch already high at reset release is not taken as an event.
REQ-029 Reset mid-transfer SHALL discard all stored records with no partial output.
REQ-030 Head field outputs SHALL read 0 after reset until the first push.

Configuration
REQ-031 With macro LPC_CAPTURE_FILTER_EN defined, an event SHALL be capturable only if dec_cyctype_dir[3:2]=2'b00 and FILT_LO <= dec_addr[15:0] <= FILT_HI; rejected events SHALL NOT count as overflow.
REQ-032 Without LPC_CAPTURE_FILTER_EN, every event in RUN SHALL be capturable; FILT_LO and FILT_HI SHALL have no effect.

Verification
REQ-033 enable=1, one event (cyctype 0x2, addr 0x0080, data 0xA5), out_ready=1 -> out_valid high for exactly 1 cycle with 0x2/0x0080/0xA5, fifo_level returns to 0.
REQ-034 DEPTH=4, out_ready=0, 6 events -> fifo_level=4, overflow_cnt=2; then out_ready=1 -> first 4 records emitted in order.
REQ-035 FIFO full, event coincident with a pop -> fifo_level stays 4, overflow_cnt unchanged, new record emitted last.
REQ-036 With LPC_CAPTURE_FILTER_EN, events at addr 0x0080 and 0x0090 -> only 0x0080 stored; without the macro -> both stored.
REQ-037 3 records queued, enable=0 -> busy stays high until 3 pops complete, then state OFF; a later event is ignored.
REQ-038 lpc_reset pulsed low with 2 records queued and dec_latch held high -> out_valid=0, overflow_cnt=0, no event after release until dec_latch toggles low then high.

Source files
------------

// File: rtl/lpc_capture_if.sv
// lpc_capture_if: signal bundle between the LPC decoder, the capture FIFO and the downstream serializer.
// Decoder side : dec_cyctype_dir[3:0], dec_addr[31:0], dec_data[7:0], dec_latch (done strobe)
// Output side  : out_valid, out_ready, out_cyctype_dir[3:0], out_addr[15:0], out_data[7:0]
// master drives the decoder fields and out_ready; slave (the capture block) drives the out_* record.
interface lpc_capture_if;
  logic [3:0]  dec_cyctype_dir;
  logic [31:0] dec_addr;
  logic [7:0]  dec_data;
  logic        dec_latch;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_cyctype_dir;
  logic [15:0] out_addr;
  logic [7:0]  out_data;
  modport master (
    output dec_cyctype_dir, dec_addr, dec_data, dec_latch, out_ready,
    input  out_valid, out_cyctype_dir, out_addr, out_data
  );
  modport slave (
    input  dec_cyctype_dir, dec_addr, dec_data, dec_latch, out_ready,
    output out_valid, out_cyctype_dir, out_addr, out_data
  );
endinterface

// File: rtl/lpc_capture_ctrl.sv
// lpc_capture_ctrl: captures completed LPC decoder transactions into a small FIFO for a serializer.
// Ports: lpc_clock (rising edge), lpc_reset (async, active-low), enable (capture run request),
//        bus (lpc_capture_if.slave: decoder fields + latch strobe in, head record out with valid/ready),
//        fifo_level (entries held), overflow_cnt (saturating drop count), busy (RUN or DRAIN).
// Optional feature: define LPC_CAPTURE_FILTER_EN to capture only I/O cycles inside FILT_LO..FILT_HI.
module lpc_capture_ctrl #(
  parameter int          DEPTH   = 4,
  parameter logic [15:0] FILT_LO = 16'h0080,
  parameter logic [15:0] FILT_HI = 16'h0087
) (
  input  logic          lpc_clock,
  input  logic          lpc_reset,
  input  logic          enable,
  lpc_capture_if.slave  bus,
  output logic [4:0]    fifo_level,
  output logic [7:0]    overflow_cnt,
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {OFF, RUN, DRAIN} state_t;
  state_t        state_q, state_d;
  logic          latch_q, latch_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [7:0]    ovf_q, ovf_d;
  logic [27:0]   mem_q [DEPTH];
  logic [27:0]   mem_d [DEPTH];
  logic          ev, filt_ok, capt, full, pop, push, drop;
  logic          unused_bits;
  // Upper address bits are never recorded; the filter bounds are idle when the filter is compiled out.
  assign unused_bits = ^{bus.dec_addr[31:16], FILT_LO, FILT_HI};
`ifdef LPC_CAPTURE_FILTER_EN
  assign filt_ok = bus.dec_cyctype_dir[3:2] == 2'b00 && bus.dec_addr[15:0] >= FILT_LO && bus.dec_addr[15:0] <= FILT_HI;
`else
  assign filt_ok = 1'b1;
`endif
  assign bus.out_valid = level_q != 5'd0;
  assign {bus.out_cyctype_dir, bus.out_addr, bus.out_data} = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign overflow_cnt = ovf_q;
  assign busy = state_q != OFF;
  always_comb begin
    ev = bus.dec_latch & ~latch_q;
    full = level_q == 5'(DEPTH);
    pop = bus.out_valid & bus.out_ready;
    capt = ev & filt_ok & (state_q == RUN);
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    push = capt & (~full | pop);
    drop = capt & full & ~pop;
    latch_d = bus.dec_latch;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d = level_q + 5'(push) - 5'(pop);
    ovf_d = ovf_q + 8'(drop & (ovf_q != 8'hFF));
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {bus.dec_cyctype_dir, bus.dec_addr[15:0], bus.dec_data};
    // DRAIN holds until the FIFO is empty; an empty FIFO can never pop, so level alone decides.
    state_d = enable ? RUN :
              (state_q == RUN) ? DRAIN :
              (state_q == DRAIN && level_q != 5'd0) ? DRAIN : OFF;
  end
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q <= OFF;
      latch_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      ovf_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_lpc_capture_ctrl.sv
// tb_lpc_capture_ctrl: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_lpc_capture_ctrl;
  localparam int DEPTH = 4;
`ifdef LPC_CAPTURE_FILTER_EN
  localparam int FILT_LVL = 1;
`else
  localparam int FILT_LVL = 2;
`endif
  logic        lpc_clock, lpc_reset, enable;
  logic [4:0]  fifo_level;
  logic [7:0]  overflow_cnt;
  logic        busy;
  int          n_tests, n_fail;
  logic [27:0] m_q[$];
  int          m_ovf;
  bit          m_latch, m_run, m_active;
  lpc_capture_if bus();
  lpc_capture_ctrl #(.DEPTH(DEPTH), .FILT_LO(16'h0080), .FILT_HI(16'h0087)) dut (
    .lpc_clock(lpc_clock),
    .lpc_reset(lpc_reset),
    .enable(enable),
    .bus(bus),
    .fifo_level(fifo_level),
    .overflow_cnt(overflow_cnt),
    .busy(busy)
  );
  initial lpc_clock = 1'b0;
  always #5 lpc_clock = ~lpc_clock;
  function automatic logic [27:0] mk(logic [3:0] c, logic [15:0] a, logic [7:0] d);
    return {c, a, d};
  endfunction
  function automatic logic [27:0] head();
    return {bus.out_cyctype_dir, bus.out_addr, bus.out_data};
  endfunction
  function automatic bit filt_ok(logic [3:0] c, logic [15:0] a);
`ifdef LPC_CAPTURE_FILTER_EN
    return c[3:2] == 2'b00 && a >= 16'h0080 && a <= 16'h0087;
`else
    return (c == c) && (a == a);
`endif
  endfunction
  task automatic model_reset();
    m_q.delete();
    m_ovf = 0;
    m_latch = 1'b1;
    m_run = 1'b0;
    m_active = 1'b0;
  endtask
  // Advance the model by one clock using the inputs currently driven, then move past the edge.
  task automatic tick();
    bit ev, pop, capt;
    ev = bus.dec_latch && !m_latch;
    pop = m_q.size() != 0 && bus.out_ready;
    capt = ev && m_run && filt_ok(bus.dec_cyctype_dir, bus.dec_addr[15:0]);
    m_active = enable || m_run || (m_active && m_q.size() != 0);
    m_run = enable;
    m_latch = bus.dec_latch;
    if (pop) void'(m_q.pop_front());
    if (capt) begin
      if (m_q.size() < DEPTH) m_q.push_back({bus.dec_cyctype_dir, bus.dec_addr[15:0], bus.dec_data});
      else if (m_ovf < 255) m_ovf++;
    end
    @(posedge lpc_clock);
    #1;
  endtask
  task automatic pulse(logic [3:0] c, logic [15:0] a, logic [7:0] d);
    bus.dec_cyctype_dir = c;
    bus.dec_addr = {16'hDEAD, a};
    bus.dec_data = d;
    bus.dec_latch = 1'b1;
    tick();
    bus.dec_latch = 1'b0;
    tick();
  endtask
  task automatic do_reset();
    lpc_reset = 1'b0;
    model_reset();
    #2;
    lpc_reset = 1'b1;
  endtask
  task automatic test_reset();
    bus.dec_latch = 1'b1;
    enable = 1'b1;
    bus.out_ready = 1'b0;
    lpc_reset = 1'b0;
    model_reset();
    #3;
    n_tests++;
    if (bus.out_valid !== 1'b0 || fifo_level !== 5'd0 || overflow_cnt !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b level=%0d ovf=%0d busy=%b, required 0/0/0/0", bus.out_valid, fifo_level, overflow_cnt, busy);
    end
    n_tests++;
    if (head() !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_head: got %h, required 0", head());
    end
    @(negedge lpc_clock);
    lpc_reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (fifo_level !== 5'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_latch_held: level=%0d busy=%b, required 0/1", fifo_level, busy);
    end
  endtask
  task automatic test_single();
    enable = 1'b1;
    bus.out_ready = 1'b1;
    bus.dec_latch = 1'b0;
    tick();
    bus.dec_cyctype_dir = 4'h2;
    bus.dec_addr = 32'h0000_0080;
    bus.dec_data = 8'hA5;
    bus.dec_latch = 1'b1;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || head() !== mk(4'h2, 16'h0080, 8'hA5) || fifo_level !== 5'd1) begin
      n_fail++;
      $display("FAIL single_capture: valid=%b head=%h level=%0d, required 1/%h/1", bus.out_valid, head(), fifo_level, mk(4'h2, 16'h0080, 8'hA5));
    end
    bus.dec_latch = 1'b0;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL single_pop: valid=%b level=%0d, required 0/0", bus.out_valid, fifo_level);
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_one_cycle: valid=%b, required 0", bus.out_valid);
    end
  endtask
  task automatic test_overflow();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) pulse(4'(i & 3), 16'h0080 + 16'(i), 8'h10 + 8'(i));
    n_tests++;
    if (fifo_level !== 5'd4 || overflow_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL overflow_count: level=%0d ovf=%0d, required 4/2", fifo_level, overflow_cnt);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || head() !== mk(4'(i & 3), 16'h0080 + 16'(i), 8'h10 + 8'(i))) begin
        n_fail++;
        $display("FAIL overflow_order[%0d]: valid=%b head=%h, required 1/%h", i, bus.out_valid, head(), mk(4'(i & 3), 16'h0080 + 16'(i), 8'h10 + 8'(i)));
      end
      tick();
    end
    n_tests++;
    if (fifo_level !== 5'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_empty: level=%0d valid=%b, required 0/0", fifo_level, bus.out_valid);
    end
  endtask
  task automatic test_full_pop();
    logic [27:0] exp_q[$];
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(4'h0, 16'h0081, 8'hB0 + 8'(i));
    exp_q = '{mk(4'h0, 16'h0081, 8'hB1), mk(4'h0, 16'h0081, 8'hB2), mk(4'h0, 16'h0081, 8'hB3), mk(4'h1, 16'h0086, 8'hC5)};
    bus.dec_cyctype_dir = 4'h1;
    bus.dec_addr = 32'h0000_0086;
    bus.dec_data = 8'hC5;
    bus.dec_latch = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    n_tests++;
    if (fifo_level !== 5'd4 || overflow_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL full_pop_level: level=%0d ovf=%0d, required 4/2", fifo_level, overflow_cnt);
    end
    bus.dec_latch = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    n_tests++;
    if (fifo_level !== 5'd4) begin
      n_fail++;
      $display("FAIL full_pop_hold: level=%0d, required 4", fifo_level);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (head() !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_pop_order[%0d]: head=%h, required %h", i, head(), exp_q[i]);
      end
      tick();
    end
    n_tests++;
    if (fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL full_pop_empty: level=%0d, required 0", fifo_level);
    end
  endtask
  task automatic test_filter();
    bus.out_ready = 1'b0;
    pulse(4'h0, 16'h0080, 8'h11);
    pulse(4'h0, 16'h0090, 8'h22);
    n_tests++;
    if (fifo_level !== 5'(FILT_LVL) || head() !== mk(4'h0, 16'h0080, 8'h11)) begin
      n_fail++;
      $display("FAIL filter_store: level=%0d head=%h, required %0d/%h", fifo_level, head(), FILT_LVL, mk(4'h0, 16'h0080, 8'h11));
    end
    bus.out_ready = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (fifo_level !== 5'd0 || overflow_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL filter_drain: level=%0d ovf=%0d, required 0/2", fifo_level, overflow_cnt);
    end
  endtask
  task automatic test_drain();
    bus.out_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) pulse(4'h0, 16'h0082, 8'h30 + 8'(i));
    enable = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b1 || fifo_level !== 5'd3) begin
      n_fail++;
      $display("FAIL drain_hold: busy=%b level=%0d, required 1/3", busy, fifo_level);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_busy[%0d]: busy=%b, required 1", i, busy);
      end
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL drain_off: busy=%b level=%0d, required 0/0", busy, fifo_level);
    end
    pulse(4'h0, 16'h0083, 8'h77);
    n_tests++;
    if (fifo_level !== 5'd0 || bus.out_valid !== 1'b0 || overflow_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL off_ignore: level=%0d valid=%b ovf=%0d, required 0/0/2", fifo_level, bus.out_valid, overflow_cnt);
    end
  endtask
  task automatic test_reset_mid();
    enable = 1'b1;
    bus.out_ready = 1'b0;
    bus.dec_latch = 1'b0;
    tick();
    pulse(4'h0, 16'h0084, 8'h41);
    pulse(4'h0, 16'h0085, 8'h42);
    n_tests++;
    if (fifo_level !== 5'd2) begin
      n_fail++;
      $display("FAIL reset_mid_fill: level=%0d, required 2", fifo_level);
    end
    bus.dec_latch = 1'b1;
    #2;
    lpc_reset = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || fifo_level !== 5'd0 || overflow_cnt !== 8'd0 || busy !== 1'b0 || head() !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b level=%0d ovf=%0d busy=%b head=%h, required 0/0/0/0/0", bus.out_valid, fifo_level, overflow_cnt, busy, head());
    end
    #1;
    lpc_reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_no_event: level=%0d, required 0", fifo_level);
    end
    bus.dec_latch = 1'b0;
    tick();
    bus.dec_latch = 1'b1;
    tick();
    n_tests++;
    if (fifo_level !== 5'd1 || head() !== mk(4'h0, 16'h0085, 8'h42)) begin
      n_fail++;
      $display("FAIL reset_mid_retoggle: level=%0d head=%h, required 1/%h", fifo_level, head(), mk(4'h0, 16'h0085, 8'h42));
    end
    bus.dec_latch = 1'b0;
    bus.out_ready = 1'b1;
    tick();
  endtask
  task automatic test_saturate();
    enable = 1'b1;
    bus.out_ready = 1'b0;
    repeat (270) pulse(4'h0, 16'h0084, 8'h5A);
    n_tests++;
    if (overflow_cnt !== 8'd255 || fifo_level !== 5'd4) begin
      n_fail++;
      $display("FAIL saturate: ovf=%0d level=%0d, required 255/4", overflow_cnt, fifo_level);
    end
  endtask
  task automatic test_random();
    do_reset();
    bus.dec_latch = 1'b0;
    for (int i = 0; i < 800; i++) begin
      enable = $urandom_range(0, 15) != 0;
      bus.dec_latch = $urandom_range(0, 1) == 1;
      bus.out_ready = $urandom_range(0, 2) == 0;
      bus.dec_cyctype_dir = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      bus.dec_addr[31:16] = 16'($urandom);
      bus.dec_addr[15:0] = $urandom_range(0, 1) ? 16'($urandom_range(16'h007E, 16'h0089)) : 16'($urandom);
      bus.dec_data = 8'($urandom);
      tick();
      n_tests++;
      if (fifo_level !== 5'(m_q.size()) || bus.out_valid !== (m_q.size() != 0) || overflow_cnt !== 8'(m_ovf) || busy !== m_active) begin
        n_fail++;
        $display("FAIL random_status[%0d]: level=%0d valid=%b ovf=%0d busy=%b, required %0d/%b/%0d/%b", i, fifo_level, bus.out_valid, overflow_cnt, busy, m_q.size(), m_q.size() != 0, m_ovf, m_active);
      end
      if (m_q.size() != 0) begin
        n_tests++;
        if (head() !== m_q[0]) begin
          n_fail++;
          $display("FAIL random_head[%0d]: head=%h, required %h", i, head(), m_q[0]);
        end
      end
    end
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    lpc_reset = 1'b0;
    enable = 1'b0;
    bus.dec_cyctype_dir = 4'h0;
    bus.dec_addr = 32'h0;
    bus.dec_data = 8'h0;
    bus.dec_latch = 1'b1;
    bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_filter();
    test_drain();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
